// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC controller.
// State encoding, fetch step and default redirect vectors.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_BAD     = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_ctrl_stall_cnt.sv
// Saturating 16-bit counter of fetch-stall cycles.
// Only instantiated when PC_CTRL_PERF_EN is defined.
module pc_ctrl_stall_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] cnt_o
);

  // count enabled cycles, stick at all-ones
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= 16'h0000;
    end else if (en_i && (cnt_o != 16'hFFFF)) begin
      cnt_o <= cnt_o + 16'd1;
    end
  end

endmodule

// File: rtl/pc_controller.sv
// Next-PC selection and fetch/pipeline hold-flush control.
// Optional PC_CTRL_PERF_EN adds stall_cnt_o, a stall-cycle counter.
module pc_controller
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        imem_ready_i,
  input  logic        load_use_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        trap_i,
  output logic [31:0] pc_next_o,
  output logic        if_redo_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        imem_req_o,
`ifdef PC_CTRL_PERF_EN
  output logic [15:0] stall_cnt_o,
`endif
  output logic [1:0]  state_o
);

  state_t state;
  state_t nxt;
  logic   redirect;
  logic   in_run;

  assign redirect   = trap_i | br_taken_i;
  assign in_run     = (state == ST_RUN) || (state == ST_BAD);
  assign imem_req_o = rst_i;
  assign state_o    = state;

  // next-PC, hold/flush controls and next state
  always_comb begin
    nxt          = ST_RUN;
    pc_next_o    = pc_i + PC_STEP;
    if_redo_o    = 1'b0;
    ifid_stall_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    if (!rst_i) begin
      pc_next_o    = RESET_PC;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (redirect) begin
      pc_next_o    = trap_i ? TRAP_VEC
                            : {br_target_i[31:2], 2'b00};
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      // an outstanding fetch returns a stale word
      nxt = (in_run && imem_ready_i) ? ST_RUN
                                     : ST_DISCARD;
    end else begin
      unique case (state)
        ST_WAIT: begin
          if (!imem_ready_i) begin
            pc_next_o    = pc_i;
            if_redo_o    = 1'b1;
            ifid_flush_o = 1'b1;
            nxt          = ST_WAIT;
          end else if (load_use_i) begin
            pc_next_o    = pc_i;
            if_redo_o    = 1'b1;
            ifid_stall_o = 1'b1;
            idex_flush_o = 1'b1;
          end
        end
        ST_DISCARD: begin
          // refetch the redirect target after the stale word
          pc_next_o    = pc_i;
          if_redo_o    = 1'b1;
          ifid_flush_o = 1'b1;
          nxt = imem_ready_i ? ST_RUN : ST_DISCARD;
        end
        default: begin
          if (load_use_i) begin
            pc_next_o    = pc_i;
            if_redo_o    = 1'b1;
            ifid_stall_o = 1'b1;
            idex_flush_o = 1'b1;
            nxt = imem_ready_i ? ST_RUN : ST_WAIT;
          end else if (!imem_ready_i) begin
            pc_next_o    = pc_i;
            if_redo_o    = 1'b1;
            ifid_flush_o = 1'b1;
            nxt          = ST_WAIT;
          end
        end
      endcase
    end
  end

  // state register; encoding 3 falls back to RUN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_RUN;
    end else begin
      state <= nxt;
    end
  end

`ifdef PC_CTRL_PERF_EN
  pc_ctrl_stall_cnt u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (if_redo_o),
    .cnt_o (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pc_controller.sv
// Directed bench for pc_controller.
// Inputs driven after the rising edge, outputs checked mid-cycle.
module tb_pc_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        imem_ready_i;
  logic        load_use_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        trap_i;
  logic [31:0] pc_next_o;
  logic        if_redo_o;
  logic        ifid_stall_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic        imem_req_o;
  logic [1:0]  state_o;
`ifdef PC_CTRL_PERF_EN
  logic [15:0] stall_cnt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  pc_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .imem_ready_i (imem_ready_i),
    .load_use_i   (load_use_i),
    .br_taken_i   (br_taken_i),
    .br_target_i  (br_target_i),
    .trap_i       (trap_i),
    .pc_next_o    (pc_next_o),
    .if_redo_o    (if_redo_o),
    .ifid_stall_o (ifid_stall_o),
    .ifid_flush_o (ifid_flush_o),
    .idex_flush_o (idex_flush_o),
    .imem_req_o   (imem_req_o),
`ifdef PC_CTRL_PERF_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .state_o      (state_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic drv(input logic [31:0] pc,
                     input logic rdy, input logic lu,
                     input logic br, input logic [31:0] tgt,
                     input logic tr);
    pc_i = pc; imem_ready_i = rdy; load_use_i = lu;
    br_taken_i = br; br_target_i = tgt; trap_i = tr;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    drv(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pc", pc_next_o, 32'h0);
    check("rst_redo", 32'(if_redo_o), 32'd0);
    check("rst_ifid_fl", 32'(ifid_flush_o), 32'd1);
    check("rst_idex_fl", 32'(idex_flush_o), 32'd1);
    check("rst_stall", 32'(ifid_stall_o), 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
`ifdef PC_CTRL_PERF_EN
    check("rst_cnt", 32'(stall_cnt_o), 32'd0);
`endif

    tick();
    rst_i = 1'b1;
    drv(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rel_pc", pc_next_o, 32'h4);
    check("rel_req", 32'(imem_req_o), 32'd1);
    check("rel_flush", 32'(ifid_flush_o | idex_flush_o), 32'd0);

    tick();
    drv(32'h40, 1'b1, 1'b0, 1'b1, 32'h83, 1'b0);
    check("br_pc", pc_next_o, 32'h80);
    check("br_ifid_fl", 32'(ifid_flush_o), 32'd1);
    check("br_idex_fl", 32'(idex_flush_o), 32'd1);
    check("br_redo", 32'(if_redo_o), 32'd0);
    tick();
    drv(32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("br_state", 32'(state_o), 32'd0);

    drv(32'h80, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1);
    check("trap_br_pc", pc_next_o, 32'h100);
    drv(32'h80, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    check("trap_lu_redo", 32'(if_redo_o), 32'd0);
    check("trap_lu_pc", pc_next_o, 32'h100);

    drv(32'h84, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    check("lu_redo", 32'(if_redo_o), 32'd1);
    check("lu_stall", 32'(ifid_stall_o), 32'd1);
    check("lu_idex_fl", 32'(idex_flush_o), 32'd1);
    check("lu_ifid_fl", 32'(ifid_flush_o), 32'd0);
    check("lu_pc", pc_next_o, 32'h84);
    tick();
    check("lu_state", 32'(state_o), 32'd0);

    for (int i = 0; i < 3; i++) begin
      drv(32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("wait_redo", 32'(if_redo_o), 32'd1);
      check("wait_ifid_fl", 32'(ifid_flush_o), 32'd1);
      check("wait_state", 32'(state_o), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    check("wait_state3", 32'(state_o), 32'd1);
    drv(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wait_done_pc", pc_next_o, 32'h204);
    check("wait_done_redo", 32'(if_redo_o), 32'd0);
    tick();
    check("wait_back_run", 32'(state_o), 32'd0);

    drv(32'h204, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    check("brnr_pc", pc_next_o, 32'h300);
    tick();
    check("disc_state", 32'(state_o), 32'd2);
    drv(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("disc_redo", 32'(if_redo_o), 32'd1);
    check("disc_ifid_fl", 32'(ifid_flush_o), 32'd1);
    tick();
    check("disc_hold", 32'(state_o), 32'd2);
    drv(32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("disc_rdy_fl", 32'(ifid_flush_o), 32'd1);
    tick();
    check("disc_run", 32'(state_o), 32'd0);

    drv(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("wrap_pc", pc_next_o, 32'h0);
    check("wrap_flush", 32'(ifid_flush_o | idex_flush_o
                           | if_redo_o | ifid_stall_o), 32'd0);

    drv(32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("mid_wait", 32'(state_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_pc", pc_next_o, 32'h0);
    tick();
    rst_i = 1'b1;
    drv(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("arst_rel_pc", pc_next_o, 32'h4);
    check("arst_rel_st", 32'(state_o), 32'd0);

`ifdef PC_CTRL_PERF_EN
    check("perf_clr", 32'(stall_cnt_o), 32'd0);
    drv(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    check("perf_one", 32'(stall_cnt_o), 32'd1);
    for (int i = 1; i < 70000; i++) tick();
    check("perf_sat", 32'(stall_cnt_o), 32'hFFFF);
    tick();
    check("perf_held", 32'(stall_cnt_o), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
